// File: rtl/line_notch_biquad_if.sv
// rtl/line_notch_biquad_if.sv - sample/result bundle for the line notch biquad
// The slave side is the filter; the master side feeds samples and consumes results.
interface line_notch_biquad_if #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 18
);
  logic                    sample_valid;
  logic signed [IN_W-1:0]  filter_input;
  logic signed [OUT_W-1:0] filter_output;
  logic                    output_valid;
  logic                    busy;
  logic                    sat_flag;
  logic                    overrun_flag;

  modport slave (
    input  sample_valid, filter_input,
    output filter_output, output_valid, busy, sat_flag, overrun_flag
  );

  modport master (
    output sample_valid, filter_input,
    input  filter_output, output_valid, busy, sat_flag, overrun_flag
  );
endinterface

// File: rtl/line_notch_biquad.sv
// rtl/line_notch_biquad.sv - Direct Form I biquad notch, one shared multiplier over 5 MAC cycles
// Rounds half-up, saturates to OUT_W and feeds the saturated value back.
module line_notch_biquad #(
  parameter int IN_W      = 14,
  parameter int OUT_W     = 18,
  parameter int COEF_W    = 18,
  parameter int COEF_FRAC = 16,
  parameter int ACC_W     = 40,
  parameter int B0        = 65536,
  parameter int B1        = 0,
  parameter int B2        = 0,
  parameter int A1        = 0,
  parameter int A2        = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_enable,
  line_notch_biquad_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_MAC4, S_DONE
  } state_t;

  localparam int XPAD = OUT_W - IN_W;
  localparam logic signed [COEF_W-1:0] C_B0 = COEF_W'(B0);
  localparam logic signed [COEF_W-1:0] C_B1 = COEF_W'(B1);
  localparam logic signed [COEF_W-1:0] C_B2 = COEF_W'(B2);
  localparam logic signed [COEF_W-1:0] C_A1 = COEF_W'(A1);
  localparam logic signed [COEF_W-1:0] C_A2 = COEF_W'(A2);
  localparam logic signed [ACC_W-1:0] RND     = {{(ACC_W-1){1'b0}}, 1'b1} << (COEF_FRAC-1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t                  r_state;
  logic signed [IN_W-1:0]  r_x0, r_x1, r_x2;
  logic signed [OUT_W-1:0] r_y1, r_y2, r_out;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_valid_q, r_busy, r_sat, r_ovr;

  logic signed [COEF_W-1:0] w_coef;
  logic signed [OUT_W-1:0]  w_opnd;
  logic                     w_sub;
  logic signed [ACC_W-1:0]  w_coef_a, w_opnd_a, w_prod;
  logic signed [ACC_W-1:0]  w_rnd_sum, w_round;
  logic                     w_hi, w_lo;
  logic signed [OUT_W-1:0]  w_sat_val;

  // Operand select for the shared multiplier; feedback taps are subtracted.
  always_comb begin
    w_coef = '0;
    w_opnd = '0;
    w_sub  = 1'b0;
    case (r_state)
      S_MAC0: begin w_coef = C_B0; w_opnd = {{XPAD{r_x0[IN_W-1]}}, r_x0}; end
      S_MAC1: begin w_coef = C_B1; w_opnd = {{XPAD{r_x1[IN_W-1]}}, r_x1}; end
      S_MAC2: begin w_coef = C_B2; w_opnd = {{XPAD{r_x2[IN_W-1]}}, r_x2}; end
      S_MAC3: begin w_coef = C_A1; w_opnd = r_y1; w_sub = 1'b1; end
      S_MAC4: begin w_coef = C_A2; w_opnd = r_y2; w_sub = 1'b1; end
      default: ;
    endcase
  end

  assign w_coef_a  = {{(ACC_W-COEF_W){w_coef[COEF_W-1]}}, w_coef};
  assign w_opnd_a  = {{(ACC_W-OUT_W){w_opnd[OUT_W-1]}}, w_opnd};
  assign w_prod    = w_coef_a * w_opnd_a;
  assign w_rnd_sum = r_acc + RND;
  assign w_round   = w_rnd_sum >>> COEF_FRAC;
  assign w_hi      = w_round > SAT_MAX;
  assign w_lo      = w_round < SAT_MIN;
  assign w_sat_val = w_hi ? SAT_MAX[OUT_W-1:0] :
                     w_lo ? SAT_MIN[OUT_W-1:0] : w_round[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_x0      <= '0;
      r_x1      <= '0;
      r_x2      <= '0;
      r_y1      <= '0;
      r_y2      <= '0;
      r_out     <= '0;
      r_acc     <= '0;
      r_valid_q <= 1'b0;
      r_busy    <= 1'b0;
      r_sat     <= 1'b0;
      r_ovr     <= 1'b0;
    end else if (clk_enable) begin
      r_valid_q <= 1'b0;
      if (bus.sample_valid && r_state != S_IDLE) r_ovr <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (bus.sample_valid) begin
            r_x0    <= bus.filter_input;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_MAC0;
          end
        end
        S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_MAC4: begin
          r_acc   <= w_sub ? r_acc - w_prod : r_acc + w_prod;
          r_state <= state_t'(r_state + 3'd1);
        end
        S_DONE: begin
          r_out     <= w_sat_val;
          r_x2      <= r_x1;
          r_x1      <= r_x0;
          r_y2      <= r_y1;
          r_y1      <= w_sat_val;
          r_valid_q <= 1'b1;
          if (w_hi || w_lo) r_sat <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.filter_output = r_out;
  assign bus.output_valid  = r_valid_q & clk_enable;
  assign bus.busy          = r_busy;
  assign bus.sat_flag      = r_sat;
  assign bus.overrun_flag  = r_ovr;
endmodule

// File: tb/tb_line_notch_biquad.sv
// tb/tb_line_notch_biquad.sv - directed bench for line_notch_biquad
// Four instances (pass-through, FIR, feedback, saturating) share one stimulus stream.
module tb_line_notch_biquad;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_enable = 1'b1;
  logic sample_valid = 1'b0;
  logic signed [13:0] filter_input = '0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  line_notch_biquad_if #(.IN_W(14), .OUT_W(18)) if_pt ();
  line_notch_biquad_if #(.IN_W(14), .OUT_W(18)) if_fir ();
  line_notch_biquad_if #(.IN_W(14), .OUT_W(18)) if_fb ();
  line_notch_biquad_if #(.IN_W(14), .OUT_W(18)) if_sat ();

  assign if_pt.sample_valid  = sample_valid;
  assign if_pt.filter_input  = filter_input;
  assign if_fir.sample_valid = sample_valid;
  assign if_fir.filter_input = filter_input;
  assign if_fb.sample_valid  = sample_valid;
  assign if_fb.filter_input  = filter_input;
  assign if_sat.sample_valid = sample_valid;
  assign if_sat.filter_input = filter_input;

  line_notch_biquad u_pt (.clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(if_pt));
  line_notch_biquad #(.B1(32768), .B2(16384)) u_fir (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(if_fir));
  line_notch_biquad #(.A1(-32768)) u_fb (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(if_fb));
  line_notch_biquad #(.A1(-65536)) u_sat (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(if_sat));

  logic signed [17:0] out_v [4];
  logic valid_v [4];
  logic busy_v [4];
  logic sat_v [4];
  logic ovr_v [4];

  assign out_v[0] = if_pt.filter_output;
  assign out_v[1] = if_fir.filter_output;
  assign out_v[2] = if_fb.filter_output;
  assign out_v[3] = if_sat.filter_output;
  assign valid_v[0] = if_pt.output_valid;
  assign valid_v[1] = if_fir.output_valid;
  assign valid_v[2] = if_fb.output_valid;
  assign valid_v[3] = if_sat.output_valid;
  assign busy_v[0] = if_pt.busy;
  assign busy_v[1] = if_fir.busy;
  assign busy_v[2] = if_fb.busy;
  assign busy_v[3] = if_sat.busy;
  assign sat_v[0] = if_pt.sat_flag;
  assign sat_v[1] = if_fir.sat_flag;
  assign sat_v[2] = if_fb.sat_flag;
  assign sat_v[3] = if_sat.sat_flag;
  assign ovr_v[0] = if_pt.overrun_flag;
  assign ovr_v[1] = if_fir.overrun_flag;
  assign ovr_v[2] = if_fb.overrun_flag;
  assign ovr_v[3] = if_sat.overrun_flag;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    clk_enable = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Issues one sample and waits for the selected instance's output_valid; lat counts from the accept cycle.
  task automatic run_sample(input int inst, input int val, output int out, output int lat);
    filter_input = 14'(val);
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    lat = 1;
    while (!valid_v[inst] && lat < 20) begin
      step();
      lat++;
    end
    out = int'(out_v[inst]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clk_enable = 1'b0;
    sample_valid = 1'b1;
    filter_input = 14'sd1234;
    step();
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (out_v[i] !== 18'sd0) begin
        n_fail++;
        $display("FAIL reset_out[%0d]: got %0d expected 0", i, out_v[i]);
      end
      n_tests++;
      if ({valid_v[i], busy_v[i], sat_v[i], ovr_v[i]} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_flags[%0d]: got %b expected 0000", i,
                 {valid_v[i], busy_v[i], sat_v[i], ovr_v[i]});
      end
    end
    sample_valid = 1'b0;
    clk_enable = 1'b1;
    reset = 1'b0;
  endtask

  task automatic test_pass_through();
    int vals[3] = '{1000, -8192, 8191};
    int out, lat;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_sample(0, vals[i], out, lat);
      n_tests++;
      if (out !== vals[i]) begin
        n_fail++;
        $display("FAIL pass_out[%0d]: got %0d expected %0d", i, out, vals[i]);
      end
      n_tests++;
      if (lat !== 7) begin
        n_fail++;
        $display("FAIL pass_latency[%0d]: got %0d expected 7", i, lat);
      end
    end
    n_tests++;
    if (sat_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_sat: got %b expected 0", sat_v[0]);
    end
  endtask

  task automatic test_fir();
    int xin[5] = '{1000, 0, 0, 0, 0};
    int exp_y[5] = '{1000, 500, 250, 0, 0};
    int out, lat;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_sample(1, xin[i], out, lat);
      n_tests++;
      if (out !== exp_y[i] || lat !== 7) begin
        n_fail++;
        $display("FAIL fir[%0d]: got %0d (lat %0d) expected %0d (lat 7)", i, out, lat, exp_y[i]);
      end
    end
  endtask

  task automatic test_feedback();
    int exp_p[7] = '{1000, 500, 250, 125, 63, 32, 16};
    int exp_n[6] = '{-1000, -500, -250, -125, -62, -31};
    int out, lat;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      run_sample(2, (i == 0) ? 1000 : 0, out, lat);
      n_tests++;
      if (out !== exp_p[i] || lat !== 7) begin
        n_fail++;
        $display("FAIL feedback_pos[%0d]: got %0d (lat %0d) expected %0d (lat 7)", i, out, lat, exp_p[i]);
      end
    end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_sample(2, (i == 0) ? -1000 : 0, out, lat);
      n_tests++;
      if (out !== exp_n[i] || lat !== 7) begin
        n_fail++;
        $display("FAIL feedback_neg[%0d]: got %0d (lat %0d) expected %0d (lat 7)", i, out, lat, exp_n[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int out, lat;
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      run_sample(3, 8191, out, lat);
      if (k == 16) begin
        n_tests++;
        if (out !== 131056 || sat_v[3] !== 1'b0) begin
          n_fail++;
          $display("FAIL sat_pos_16: got %0d sat %b expected 131056 sat 0", out, sat_v[3]);
        end
      end else if (k >= 17) begin
        n_tests++;
        if (out !== 131071 || sat_v[3] !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_pos_%0d: got %0d sat %b expected 131071 sat 1", k, out, sat_v[3]);
        end
      end
    end
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      run_sample(3, -8192, out, lat);
      if (k == 16) begin
        n_tests++;
        if (out !== -131072 || sat_v[3] !== 1'b0) begin
          n_fail++;
          $display("FAIL sat_neg_16: got %0d sat %b expected -131072 sat 0", out, sat_v[3]);
        end
      end else if (k >= 17) begin
        n_tests++;
        if (out !== -131072 || sat_v[3] !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_neg_%0d: got %0d sat %b expected -131072 sat 1", k, out, sat_v[3]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int out, lat, nv;
    do_reset();
    filter_input = 14'sd555;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    step();
    filter_input = 14'sd777;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    lat = 4;
    while (!valid_v[0] && lat < 20) begin
      step();
      lat++;
    end
    n_tests++;
    if (lat !== 7 || out_v[0] !== 18'sd555) begin
      n_fail++;
      $display("FAIL overrun_result: got %0d (lat %0d) expected 555 (lat 7)", out_v[0], lat);
    end
    n_tests++;
    if (ovr_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_flag: got ovr %b busy %b expected ovr 1 busy 0", ovr_v[0], busy_v[0]);
    end
    run_sample(0, 321, out, lat);
    n_tests++;
    if (out !== 321 || lat !== 7) begin
      n_fail++;
      $display("FAIL accept_t7: got %0d (lat %0d) expected 321 (lat 7)", out, lat);
    end
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (valid_v[0]) nv++;
    end
    n_tests++;
    if (nv !== 0) begin
      n_fail++;
      $display("FAIL overrun_extra_valid: got %0d pulses expected 0", nv);
    end
  endtask

  task automatic test_clk_enable();
    int xin[2] = '{1000, 0};
    int exp_y[2] = '{1000, 500};
    int nv, got;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      filter_input = 14'(xin[s]);
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      nv = 0;
      got = -99999;
      for (int i = 0; i < 30; i++) begin
        clk_enable = !((i % 3) == 1 || i == 9);
        #1;
        if (valid_v[2]) begin
          nv++;
          got = int'(out_v[2]);
        end
        step();
      end
      clk_enable = 1'b1;
      n_tests++;
      if (nv !== 1 || got !== exp_y[s]) begin
        n_fail++;
        $display("FAIL clk_enable[%0d]: got %0d pulses value %0d expected 1 pulse value %0d",
                 s, nv, got, exp_y[s]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int out, lat, nv;
    do_reset();
    run_sample(2, 1000, out, lat);
    n_tests++;
    if (out !== 1000) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got %0d expected 1000", out);
    end
    filter_input = 14'sd400;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid_v[2]) nv++;
      step();
    end
    n_tests++;
    if (nv !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_valid: got %0d pulses expected 0", nv);
    end
    n_tests++;
    if (out_v[2] !== 18'sd0 || {busy_v[2], sat_v[2], ovr_v[2]} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_state: got out %0d flags %b expected 0 000",
               out_v[2], {busy_v[2], sat_v[2], ovr_v[2]});
    end
    run_sample(2, 1000, out, lat);
    n_tests++;
    if (out !== 1000 || lat !== 7) begin
      n_fail++;
      $display("FAIL reset_mid_post0: got %0d (lat %0d) expected 1000 (lat 7)", out, lat);
    end
    run_sample(2, 0, out, lat);
    n_tests++;
    if (out !== 500) begin
      n_fail++;
      $display("FAIL reset_mid_post1: got %0d expected 500", out);
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_fir();
    test_feedback();
    test_saturation();
    test_back_to_back();
    test_clk_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
